ax_bx_sequencer: RTL

Instruction fetch/issue controller for the 2-register (AX, BX) machine: fetches 6-bit instruction words from external program memory over a req/ack handshake, decodes opcode and register fields, and executes them on its internal AX/BX register file. It is the initiator side of the instruction interface that the per-opcode execution slices (AND AX/BX and siblings) respond to. It sits between program ROM and the observable register outputs.

---
 rtl/ax_bx_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ax_bx_sequencer.sv
// Fetch/issue controller for the two-register (AX, BX) machine.
// Fetches 6-bit instructions over req/ack and executes them on an internal AX/BX file.
module ax_bx_sequencer #(
  parameter int ADDR_W = 4,
  parameter int W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      ax_init,
  input  logic [W-1:0]      bx_init,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [5:0]        mem_data,
  output logic [W-1:0]      ax,
  output logic [W-1:0]      bx,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [7:0]        retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [W-1:0]        ax_q, ax_d;
  logic [W-1:0]        bx_q, bx_d;
  logic                err_q, err_d;
  logic [7:0]          retired_q, retired_d;
  logic [5:0]          ir_q, ir_d;

  // Execute-stage intermediates
  logic [W-1:0]        src1, src2, result;
  logic                legal, is_halt;

  // NOTE: reset is synchronous, so it lives inside the clocked block and every
  // flop (including the instruction register) is cleared for a deterministic restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ax_q      <= '0;
      bx_q      <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
      ir_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      pc_q      <= pc_d;
      ax_q      <= ax_d;
      bx_q      <= bx_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      ir_q      <= ir_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ax_d      = ax_q;
    bx_d      = bx_q;
    err_d     = err_q;
    retired_d = retired_q;
    ir_d      = ir_q;
    src1      = ir_q[1] ? bx_q : ax_q;
    src2      = ir_q[0] ? bx_q : ax_q;
    result    = src1;
    legal     = 1'b1;
    is_halt   = 1'b0;

    unique case (ir_q[5:2])
      OP_NOP:  result = src1;
      OP_MOV:  result = src2;
      OP_OR:   result = src1 | src2;
      OP_XOR:  result = src1 ^ src2;
      OP_NOT:  result = ~src1;
      OP_AND:  result = src1 & src2;
      OP_HALT: is_halt = 1'b1;
      default: legal = 1'b0;
    endcase

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ax_d      = ax_init;
          bx_d      = bx_init;
          pc_d      = '0;
          err_d     = 1'b0;
          retired_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (legal) begin
          if (ir_q[1]) bx_d = result;
          else         ax_d = result;
          pc_d = pc_q + ADDR_W'(1);
          if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;
          state_d = is_halt ? S_DONE : S_FETCH;
        end else begin
          // Illegal opcode: flag it and stop without touching PC or registers.
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr = pc_q;
  assign mem_req  = (state_q == S_FETCH);
  assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted   = (state_q == S_DONE);
  assign err      = err_q;
  assign ax       = ax_q;
  assign bx       = bx_q;
  assign retired  = retired_q;

endmodule
